// File: rtl/dac_counter.sv
// -----------------------------------------------------------------------------
// dac_counter
//
// Free-running sample-index counter for the audio DAC path. While the upstream
// divider strobe at_max is high the index advances by one per clock and wraps
// modulo 2^WIDTH, so the lookup it drives sweeps one full waveform period
// continuously. When at_max is low the index is cleared (not held), which
// restarts the waveform from its first sample.
//
// Ports
//   clk       in   1      system clock, rising-edge active
//   nRst      in   1      asynchronous active-low reset, clears dacCount
//   at_max    in   1      count enable; low clears the count on the next edge
//   dacCount  out  WIDTH  current sample index, driven straight from a flop
// -----------------------------------------------------------------------------
module dac_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             at_max,
    output logic [WIDTH-1:0] dacCount
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;

    // Next-state selection: increment wraps naturally at the register width.
    always_comb begin
        next_count_s = ZERO;
        if (at_max) begin
            next_count_s = count_r + ONE;
        end else begin
            next_count_s = ZERO;
        end
    end

    // Sample-index state register with asynchronous clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_r <= ZERO;
        end else begin
            count_r <= next_count_s;
        end
    end

    // No logic between the state register and the output.
    assign dacCount = count_r;

endmodule

// File: tb/tb_dac_counter.sv
// -----------------------------------------------------------------------------
// tb_dac_counter
//
// Directed self-checking bench for dac_counter. Inputs change on the falling
// edge of tb_clk and dacCount is sampled on the falling edge, away from the
// active rising edge. Expected values are hand-computed constants or a simple
// running index maintained by the bench.
// -----------------------------------------------------------------------------
module tb_dac_counter;

    localparam int WIDTH = 8;

    logic             tb_clk;
    logic             nRst;
    logic             at_max;
    logic [WIDTH-1:0] dacCount;

    int check_count;
    int error_count;

    dac_counter #(.WIDTH(WIDTH)) dut (
        .clk      (tb_clk),
        .nRst     (nRst),
        .at_max   (at_max),
        .dacCount (dacCount)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply at_max for one rising edge and return at the following falling edge.
    task automatic step(input logic en);
        at_max = en;
        @(negedge tb_clk);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_v;
        logic             pattern [6];
        logic [WIDTH-1:0] pattern_exp [6];

        check_count = 0;
        error_count = 0;

        // 1. Power-on reset.
        nRst   = 1'b0;
        at_max = 1'b0;
        #1;
        check_val("por_before_edge", dacCount, 8'd0);
        @(negedge tb_clk);
        check_val("por_after_edge", dacCount, 8'd0);
        at_max = 1'b1;
        @(negedge tb_clk);
        check_val("por_held_with_en", dacCount, 8'd0);
        nRst = 1'b1;
        step(1'b0);
        check_val("release_en_low", dacCount, 8'd0);

        // 2. Count 25 edges.
        for (int i = 0; i < 25; i++) step(1'b1);
        check_val("count_25", dacCount, 8'd25);

        // 3. Clear from 25.
        step(1'b0);
        check_val("clear_from_25", dacCount, 8'd0);

        // 4. Wrap: 300 edges, every step +1 mod 256.
        exp_v = 8'd0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            exp_v = exp_v + 8'd1;
            check_val("wrap_step", dacCount, exp_v);
        end
        check_val("wrap_300", dacCount, 8'd44);

        // Clear from 255 within a single edge.
        step(1'b0);
        for (int i = 0; i < 255; i++) step(1'b1);
        check_val("reach_255", dacCount, 8'd255);
        step(1'b0);
        check_val("clear_from_255", dacCount, 8'd0);

        // 5. Async reset mid-count.
        for (int i = 0; i < 100; i++) step(1'b1);
        check_val("count_100", dacCount, 8'd100);
        #2;
        nRst = 1'b0;
        #1;
        check_val("async_reset", dacCount, 8'd0);
        @(negedge tb_clk);
        check_val("reset_held_edge", dacCount, 8'd0);
        nRst = 1'b1;
        step(1'b1);
        check_val("resume_1", dacCount, 8'd1);
        step(1'b1);
        check_val("resume_2", dacCount, 8'd2);
        step(1'b1);
        check_val("resume_3", dacCount, 8'd3);

        // 6. Toggle enable pattern 1,1,1,0,1,1 from 0.
        step(1'b0);
        check_val("toggle_start", dacCount, 8'd0);
        pattern     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        pattern_exp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
        for (int i = 0; i < 6; i++) begin
            step(pattern[i]);
            check_val("toggle", dacCount, pattern_exp[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
